// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the single-clock level FIFO.
package sync_fifo_pkg;

  // Level counter width: one bit wider than the pointers so DEPTH itself fits.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Number of storage entries; every slot is usable.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_level_if.sv
// Bus bundle for sync_fifo_level. Optional error flags appear when
// SYNC_FIFO_ERR_FLAGS_EN is defined.
//
// Request semantics: wr_en_i/rd_en_i are requests sampled every rising edge.
// A write is taken when wr_en_i && !full_o, a read when rd_en_i && !empty_o,
// and flush_i overrides both. Refused requests are dropped with no retry;
// rd_valid_o pulses one cycle after each taken read, with rd_data_o.
interface sync_fifo_level_if
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                                 flush_i;
  logic                                 wr_en_i;
  logic [DATA_WIDTH-1:0]                wr_data_i;
  logic                                 rd_en_i;
  logic [DATA_WIDTH-1:0]                rd_data_o;
  logic                                 rd_valid_o;
  logic [level_width(ADDR_WIDTH)-1:0]   afull_thresh_i;
  logic [level_width(ADDR_WIDTH)-1:0]   aempty_thresh_i;
  logic [level_width(ADDR_WIDTH)-1:0]   level_o;
  logic                                 full_o;
  logic                                 a_full_o;
  logic                                 empty_o;
  logic                                 a_empty_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                                 overflow_o;
  logic                                 underflow_o;
`endif

  modport master (
    output flush_i, wr_en_i, wr_data_i, rd_en_i, afull_thresh_i, aempty_thresh_i,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  overflow_o, underflow_o,
`endif
    input  rd_data_o, rd_valid_o, level_o, full_o, a_full_o, empty_o, a_empty_o
  );

  modport slave (
    input  flush_i, wr_en_i, wr_data_i, rd_en_i, afull_thresh_i, aempty_thresh_i,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output overflow_o, underflow_o,
`endif
    output rd_data_o, rd_valid_o, level_o, full_o, a_full_o, empty_o, a_empty_o
  );
endinterface

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: one write port, one registered read port.
// No control logic; the caller decides when ports are enabled.
module fifo_ram_sdp #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output register clears on reset and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with exact fill level, programmable almost-full/empty
// thresholds, synchronous flush and a read-valid strobe.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module sync_fifo_level
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  sync_fifo_level_if.slave   fifo
);
  localparam int LW = level_width(ADDR_WIDTH);
  localparam logic [LW-1:0]         DEPTH_LV = LW'(fifo_depth(ADDR_WIDTH));
  localparam logic [LW-1:0]         LEVEL_ONE = LW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]         level, level_nxt;
  logic                  full, empty, a_full, a_empty, rd_valid;
  logic                  wr_acc, rd_acc;

  // Flush outranks both requests; full/empty gate the rest.
  assign wr_acc = fifo.wr_en_i && !full  && !fifo.flush_i;
  assign rd_acc = fifo.rd_en_i && !empty && !fifo.flush_i;

  fifo_ram_sdp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (fifo.wr_data_i),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (fifo.rd_data_o)
  );

  // Next fill level: net effect of this cycle's accepted transfers.
  always_comb begin
    level_nxt = level;
    if (fifo.flush_i)          level_nxt = '0;
    else if (wr_acc && !rd_acc) level_nxt = level + LEVEL_ONE;
    else if (rd_acc && !wr_acc) level_nxt = level - LEVEL_ONE;
  end

  // Pointers wrap naturally at DEPTH; flush rewinds both.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fifo.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Level and flags registered from the next level so they never lag level_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      a_full   <= 1'b0;
      a_empty  <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      level    <= level_nxt;
      full     <= (level_nxt == DEPTH_LV);
      empty    <= (level_nxt == '0);
      a_full   <= (level_nxt >= fifo.afull_thresh_i);
      a_empty  <= (level_nxt <= fifo.aempty_thresh_i);
      rd_valid <= rd_acc;
    end
  end

  assign fifo.level_o    = level;
  assign fifo.full_o     = full;
  assign fifo.empty_o    = empty;
  assign fifo.a_full_o   = a_full;
  assign fifo.a_empty_o  = a_empty;
  assign fifo.rd_valid_o = rd_valid;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow, underflow;

  // Sticky error flags; flush clears them and wins over a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (fifo.flush_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo.wr_en_i && full)  overflow  <= 1'b1;
      if (fifo.rd_en_i && empty) underflow <= 1'b1;
    end
  end

  assign fifo.overflow_o  = overflow;
  assign fifo.underflow_o = underflow;
`endif
endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level (ADDR_WIDTH=4, DATA_WIDTH=32).
// Reference model: a queue of stored words plus expected strobe/data/flags.
module tb_sync_fifo_level;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_afull, exp_aempty;
  logic          exp_ovf, exp_unf;
  logic [AW:0]   afull, aempty;

  sync_fifo_level_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fif ();

  sync_fifo_level #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .fifo    (fif)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = exp_q.size();
    check("level",    64'(fif.level_o),   64'(lvl));
    check("empty",    64'(fif.empty_o),   64'(lvl == 0));
    check("full",     64'(fif.full_o),    64'(lvl == DEPTH));
    check("a_full",   64'(fif.a_full_o),  64'(exp_afull));
    check("a_empty",  64'(fif.a_empty_o), 64'(exp_aempty));
    check("rd_valid", 64'(fif.rd_valid_o), 64'(exp_valid));
    check("rd_data",  64'(fif.rd_data_o), 64'(exp_data));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow",  64'(fif.overflow_o),  64'(exp_ovf));
    check("underflow", 64'(fif.underflow_o), 64'(exp_unf));
`endif
  endtask

  // Async reset: check immediately after assertion and after the hold.
  task automatic do_reset();
    fif.flush_i = 1'b0; fif.wr_en_i = 1'b0; fif.rd_en_i = 1'b0; fif.wr_data_i = '0;
    fif.afull_thresh_i = afull; fif.aempty_thresh_i = aempty;
    rst_n = 1'b0;
    exp_q.delete();
    exp_data = '0; exp_valid = 1'b0; exp_afull = 1'b0; exp_aempty = 1'b1;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    #1 check_outputs();
    repeat (3) @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock with the given requests, then compare against the model.
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic fl);
    int   lvl;
    logic wr_ok, rd_ok;
    fif.wr_en_i = wr; fif.wr_data_i = wd; fif.rd_en_i = rd; fif.flush_i = fl;
    fif.afull_thresh_i = afull; fif.aempty_thresh_i = aempty;
    lvl   = exp_q.size();
    wr_ok = wr && !fl && (lvl < DEPTH);
    rd_ok = rd && !fl && (lvl > 0);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (wr && lvl == DEPTH) exp_ovf = 1'b1;
      if (rd && lvl == 0)     exp_unf = 1'b1;
      exp_valid = rd_ok;
      if (rd_ok) exp_data = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(wd);
    end
    exp_afull  = (exp_q.size() >= int'(afull));
    exp_aempty = (exp_q.size() <= int'(aempty));
    #1 check_outputs();
  endtask

  task automatic fill_to(input int n);
    while (exp_q.size() < n) step(1'b1, $urandom(), 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    afull = 5'd12; aempty = 5'd3;
    #2 do_reset();

    // Read on empty is ignored
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, drop a 17th write, retune afull above depth, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    afull = 5'd20;
    step(1'b0, '0, 1'b0, 1'b0);
    afull = 5'd12;
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Preload 8, then 40 cycles of simultaneous read/write across the wrap
    fill_to(8);
    for (int i = 0; i < 40; i++) step(1'b1, $urandom(), 1'b1, 1'b0);
    fill_to(DEPTH);
    step(1'b1, 32'h5A5A, 1'b1, 1'b0);
    drain();
    step(1'b1, 32'h77, 1'b1, 1'b0);

    // Flush at level 10 with both requests, then a clean write/read
    fill_to(10);
    step(1'b1, 32'h1234, 1'b1, 1'b1);
    step(1'b1, 32'hCAFE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Error flags: overflow, sticky after drain, underflow, flush clears
    fill_to(DEPTH);
    step(1'b1, 32'hBAD0, 1'b0, 1'b0);
    drain();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Zero afull threshold and thresholds above depth
    afull = 5'd0;
    do_reset();
    step(1'b0, '0, 1'b0, 1'b0);
    afull = 5'd31; aempty = 5'd31;
    fill_to(DEPTH);
    drain();
    afull = 5'd12; aempty = 5'd3;

    // Random traffic with occasional flush, threshold changes and a mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if ($urandom_range(0, 19) == 0) begin
        afull  = 5'($urandom_range(0, 20));
        aempty = 5'($urandom_range(0, 20));
      end
      step(($urandom_range(0, 99) < 55), $urandom(), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_level.md
Name: sync_fifo_level

Overview:
- Single-clock, parametrised successor to the team's dual-clock simple FIFO, used for same-domain buffering of sample and packet words.
- Uses all 2**ADDR_WIDTH entries; the previous FIFO wasted one slot.
- Adds an exact fill level, runtime-programmable almost-full/almost-empty thresholds, a synchronous flush and a read-data valid strobe.

Parameters:
- ADDR_WIDTH, 9, log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, word width in bits.

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush; empties the FIFO
- wr_en_i  in  1  write request
- wr_data_i  in  DATA_WIDTH  write data
- rd_en_i  in  1  read request
- rd_data_o  out  DATA_WIDTH  registered read data
- rd_valid_o  out  1  one-cycle strobe; rd_data_o holds a newly read word
- afull_thresh_i  in  ADDR_WIDTH+1  almost-full threshold (level units)
- aempty_thresh_i  in  ADDR_WIDTH+1  almost-empty threshold (level units)
- level_o  out  ADDR_WIDTH+1  current fill level, 0..DEPTH
- full_o  out  1  level_o == DEPTH
- a_full_o  out  1  level_o >= afull_thresh_i
- empty_o  out  1  level_o == 0
- a_empty_o  out  1  level_o <= aempty_thresh_i

Behaviour:
- Reset (rst_n_i low, async assert): pointers=0, level_o=0, empty_o=1, a_empty_o=1, full_o=0, a_full_o=0, rd_valid_o=0, rd_data_o=0. Memory contents are not reset.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. level_o is a separate ADDR_WIDTH+1 bit counter.
- Write accepted when wr_en_i && !full_o. mem[wr_ptr]<=wr_data_i, wr_ptr+1. A write while full is dropped silently; pointers and level are unchanged.
- Read accepted when rd_en_i && !empty_o. rd_data_o<=mem[rd_ptr], rd_ptr+1, rd_valid_o=1 next cycle. Read latency is 1 cycle.
  - A read while empty is ignored, and rd_valid_o=0.
  - rd_data_o holds its last value when no read is accepted.
- Level update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags: all registered and computed from the next-cycle level and the current thresholds, so they agree with level_o in every cycle. No off-by-one lag.
- Simultaneous read+write:
  - When full: the read is accepted, the write is rejected (full_o gates it). Level becomes DEPTH-1.
  - When empty: the write is accepted, the read is rejected. Level becomes 1.
- Write-to-read: a write at cycle N clears empty_o at N+1. A read issued at N+1 presents the data at N+2. No same-cycle bypass.
- Flush (flush_i=1):
  - Highest priority; wr_en_i/rd_en_i are ignored that cycle.
  - Next cycle: pointers=0, level=0, empty_o=1, full_o=0, rd_valid_o=0; a_full_o/a_empty_o re-evaluated at level 0.
  - rd_data_o holds.
- Thresholds may change at any time; the new flag values appear 1 cycle later.
- afull_thresh_i=0 makes a_full_o=1 from the first clock after reset release.
- Thresholds above DEPTH are legal: a_full_o never asserts and a_empty_o stays asserted.
- Reset mid-operation: immediate return to the reset values; all stored data is lost.

Optional Feature:
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow_o and underflow_o (1 bit each, reset 0).
  - overflow_o is a sticky flag set on wr_en_i && full_o.
  - underflow_o is a sticky flag set on rd_en_i && empty_o.
  - Both are cleared only by flush_i or reset; flush wins over a same-cycle set.
- Undefined: the ports and logic are absent; illegal requests are still dropped silently.

Decomposition:
- Package sync_fifo_pkg: level width function/constant (ADDR_WIDTH+1), DEPTH computation helper.
- Sub-module fifo_ram_sdp:
  - Simple dual-port RAM, one write port, one registered read port, DATA_WIDTH x 2**ADDR_WIDTH.
  - Maps to block RAM; holds no control logic.
- All pointer, level, flag and flush logic stays in sync_fifo_level.

Test Plan (ADDR_WIDTH=4, DEPTH=16, DATA_WIDTH=32):
- Reset: hold rst_n_i low for 3 cycles and release -> empty_o=1, full_o=0, level_o=0, rd_valid_o=0. Read on empty -> no rd_valid_o, level_o stays 0.
- Fill to full: write 0x100..0x10F on 16 consecutive cycles.
  - level_o=16 and full_o=1 the cycle after the last write.
  - A 17th write of 0xDEAD is dropped; level_o stays 16.
  - Reading 16 words returns 0x100..0x10F in order, each one cycle after its request, then empty_o=1.
- Wrap plus simultaneous read/write: preload 8 words, then 40 cycles with wr_en_i=rd_en_i=1 -> level_o constant at 8, data in order across pointer wrap. At full, a simultaneous read+write gives level_o=15.
- Thresholds: afull=12, aempty=3.
  - a_full_o rises in the same cycle level_o reaches 12.
  - a_empty_o falls when level_o goes 3->4.
  - Changing afull to 20 at level 16 drops a_full_o one cycle later.
- Flush: at level 10, assert flush_i together with wr_en_i and rd_en_i.
  - Next cycle: level_o=0, empty_o=1, rd_valid_o=0, rd_data_o unchanged.
  - A subsequent write/read of 0xCAFE returns 0xCAFE.
- Error flags (SYNC_FIFO_ERR_FLAGS_EN): write while full -> overflow_o=1 and stays set after draining. Read while empty -> underflow_o=1. flush_i clears both.
